// File: rtl/pipe_hazard_ctrl_pkg.sv
// Purpose: shared encodings for the pipeline hazard controller (memory FSM states, forwarding selects).
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package pipe_hazard_ctrl_pkg;

    // Data-memory wait-state FSM encoding, also exported on the mem_state debug port.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RELEASE = 2'd2
    } mem_state_e;

    // EXE operand mux selects.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    // The younger producer (EXE) holds the newest value, so it wins a double match.
    function automatic fwd_sel_e fwd_pick(input logic ex_hit, input logic mem_hit);
        if (ex_hit) begin
            return FWD_MEM;
        end
        if (mem_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose: bundle of decoded-register/stage-control inputs and freeze/flush/forward outputs of the hazard controller.
// Latency: n/a (wires only).
// Backpressure: n/a; freeze_* outputs are the pipeline's stall mechanism.
// Modports: master = core side (drives stage info, receives controls); slave = controller.
interface pipe_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_src1_vld;
    logic                  id_src2_vld;
    logic [REG_ADDR_W-1:0] ex_dest;
    logic                  ex_wb_en;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_wb_en;
    logic                  mem_access;
    logic                  branch_taken;

    logic                  freeze_front;
    logic                  freeze_all;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic [1:0]            fwd_sel_a;
    logic [1:0]            fwd_sel_b;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      flush_cnt;
    logic [1:0]            mem_state;

    modport master (
        output id_src1, id_src2, id_src1_vld, id_src2_vld,
        output ex_dest, ex_wb_en, ex_mem_read,
        output mem_dest, mem_wb_en, mem_access, branch_taken,
        input  freeze_front, freeze_all, flush_if_id, flush_id_ex,
        input  fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt, mem_state
    );

    modport slave (
        input  id_src1, id_src2, id_src1_vld, id_src2_vld,
        input  ex_dest, ex_wb_en, ex_mem_read,
        input  mem_dest, mem_wb_en, mem_access, branch_taken,
        output freeze_front, freeze_all, flush_if_id, flush_id_ex,
        output fwd_sel_a, fwd_sel_b, stall_cnt, flush_cnt, mem_state
    );

endinterface

// File: rtl/pipe_hazard_ctrl_mem_wait_fsm.sv
// Purpose: RUN/WAIT/RELEASE FSM stretching each data-memory access by MEM_WAIT stall cycles.
// Latency: mem_stall is combinational from state and mem_access; state updates on the next edge.
// Backpressure: mem_stall freezes the whole pipe; RELEASE lets the access retire without re-triggering.
// Ports: clk, rst (sync, active-high), mem_access in; mem_stall, mem_state out.
module mem_wait_fsm
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mem_access,
    output logic       mem_stall,
    output logic [1:0] mem_state
);

    // The trigger cycle in RUN and the final RELEASE-bound WAIT cycle both count,
    // so WAIT only needs MEM_WAIT-2 further cycles after the first.
    localparam logic [3:0] CNT_INIT = (MEM_WAIT >= 2) ? 4'(MEM_WAIT - 2) : 4'd0;

    mem_state_e state_q;
    mem_state_e state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_access && (MEM_WAIT != 0)) begin
                    if (MEM_WAIT == 1) begin
                        state_d = ST_RELEASE;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_comb begin
        mem_stall = ((state_q == ST_RUN) && mem_access && (MEM_WAIT != 0)) ||
                    (state_q == ST_WAIT);
        mem_state = state_q;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: central freeze/flush/forwarding control for the 5-stage pipe (RAW, load-use, branch, memory waits).
// Latency: freeze/flush combinational; forwarding selects registered (aligned with ID/EX); counters +1 cycle.
// Backpressure: freeze_all stalls every stage during memory waits; freeze_front holds PC and IF/ID on hazards.
// Ports: clk, rst (sync, active-high); ctl = pipe_hazard_ctrl_if.slave carrying stage info in, controls out.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = 4,
    parameter int FWD_EN     = 1,
    parameter int MEM_WAIT   = 0,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   ctl
);
    import pipe_hazard_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [REG_ADDR_W-1:0] src1, src2, ex_dest, mem_dest;
    logic m1_ex, m2_ex, m1_mem, m2_mem;
    logic raw_ex, raw_mem, hazard;
    logic mem_stall;
    logic freeze_front, flush_if_id, flush_id_ex;
    fwd_sel_e fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    assign src1     = ctl.id_src1;
    assign src2     = ctl.id_src2;
    assign ex_dest  = ctl.ex_dest;
    assign mem_dest = ctl.mem_dest;

    mem_wait_fsm #(
        .MEM_WAIT (MEM_WAIT)
    ) u_mem_wait_fsm (
        .clk        (clk),
        .rst        (rst),
        .mem_access (ctl.mem_access),
        .mem_stall  (mem_stall),
        .mem_state  (ctl.mem_state)
    );

    always_comb begin
        m1_ex   = ctl.id_src1_vld && (src1 == ex_dest);
        m2_ex   = ctl.id_src2_vld && (src2 == ex_dest);
        m1_mem  = ctl.id_src1_vld && (src1 == mem_dest);
        m2_mem  = ctl.id_src2_vld && (src2 == mem_dest);
        raw_ex  = ctl.ex_wb_en  && (m1_ex  || m2_ex);
        raw_mem = ctl.mem_wb_en && (m1_mem || m2_mem);
        // With forwarding only a load in EXE is too late to bypass; without it any pending write stalls.
        hazard  = (FWD_EN != 0) ? (raw_ex && ctl.ex_mem_read) : (raw_ex || raw_mem);

        // A branch seen during a memory stall is simply deferred: EXE is frozen so branch_taken persists.
        flush_if_id  = ctl.branch_taken && !mem_stall;
        flush_id_ex  = !mem_stall && (ctl.branch_taken || hazard);
        // The ID instruction is squashed by a taken branch, so there is nothing left to hold for.
        freeze_front = mem_stall || (hazard && !ctl.branch_taken);

        fwd_a_d = fwd_pick(ctl.ex_wb_en && m1_ex, ctl.mem_wb_en && m1_mem);
        fwd_b_d = fwd_pick(ctl.ex_wb_en && m2_ex, ctl.mem_wb_en && m2_mem);
    end

    // Selects track the ID/EX register: load on advance, clear with the bubble, hold while frozen.
    always_ff @(posedge clk) begin
        if (rst || (FWD_EN == 0)) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else if (!mem_stall) begin
            if (flush_id_ex) begin
                fwd_a_q <= FWD_RF;
                fwd_b_q <= FWD_RF;
            end else begin
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((freeze_front || mem_stall) && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_if_id && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign ctl.freeze_front = freeze_front;
    assign ctl.freeze_all   = mem_stall;
    assign ctl.flush_if_id  = flush_if_id;
    assign ctl.flush_id_ex  = flush_id_ex;
    assign ctl.fwd_sel_a    = fwd_a_q;
    assign ctl.fwd_sel_b    = fwd_b_q;
    assign ctl.stall_cnt    = stall_cnt_q;
    assign ctl.flush_cnt    = flush_cnt_q;

endmodule
